// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Optional stalled-owner timeout is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_PKT_LEN    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_PKT_LEN);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    if (NUM_REQ < 1 || NUM_REQ > 16 || MAX_PKT_LEN < 1 || MAX_PKT_LEN > 255 || TIMEOUT_CYCLES < 1)
    begin : g_bad_params
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   owner_reg, owner_next;
    logic [PTR_W-1:0]   last_ptr_reg, last_ptr_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [7:0]         byte_cnt_reg, byte_cnt_next;

    logic [7:0]         lane_data [NUM_REQ];
    logic [PTR_W-1:0]   win_idx;
    logic               win_found;
    logic               handshake;
    logic               release_now;
    int                 scan_idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);
    logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic               timeout_reg, timeout_next;
`endif

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane_data[gi] = req_data[8*gi +: 8];
    end

    // Rotating priority: scan starts just after the previous owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(last_ptr_reg) + k) % NUM_REQ;
            if (!win_found && req_valid[PTR_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(scan_idx);
            end
        end
    end

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        if (state_reg == XFER) begin
            tx_valid             = req_valid[owner_reg];
            req_ready[owner_reg] = tx_ready;
            if (req_valid[owner_reg]) begin
                tx_data = lane_data[owner_reg];
            end
        end
    end

    assign handshake = tx_valid && tx_ready;
    assign grant     = grant_reg;
    assign busy      = (state_reg == XFER);
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = timeout_reg;
`endif

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        last_ptr_next = last_ptr_reg;
        grant_next    = grant_reg;
        byte_cnt_next = byte_cnt_reg;
        release_now   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        stall_cnt_next = stall_cnt_reg;
        timeout_next   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next          = XFER;
                    owner_next          = win_idx;
                    grant_next          = '0;
                    grant_next[win_idx] = 1'b1;
                    byte_cnt_next       = '0;
                end
            end
            XFER: begin
                if (handshake) begin
                    byte_cnt_next = byte_cnt_reg + 8'd1;
                    if (req_last[owner_reg] || byte_cnt_next == MAX_LEN) begin
                        release_now = 1'b1;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                if (req_valid[owner_reg]) begin
                    stall_cnt_next = '0;
                end else if (stall_cnt_reg == STALL_LIMIT) begin
                    release_now  = 1'b1;
                    timeout_next = 1'b1;
                end else begin
                    stall_cnt_next = stall_cnt_reg + 1'b1;
                end
`endif
                if (release_now) begin
                    state_next    = IDLE;
                    grant_next    = '0;
                    last_ptr_next = owner_reg;
                    byte_cnt_next = '0;
`ifdef UART_ARB_TIMEOUT_EN
                    stall_cnt_next = '0;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            last_ptr_reg <= LAST_IDX;
            grant_reg    <= '0;
            byte_cnt_reg <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt_reg <= '0;
            timeout_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            last_ptr_reg <= last_ptr_next;
            grant_reg    <= grant_next;
            byte_cnt_reg <= byte_cnt_next;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt_reg <= stall_cnt_next;
            timeout_reg   <= timeout_next;
`endif
        end
    end

endmodule
